serial_parity_rx: RTL
=====================

SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: clock cycles per serial bit; the block SHALL support even values from 4 to 1024.
REQ-002 Port clk, input, 1 bit: the single clock; every flop SHALL be rising-edge triggered on clk.
REQ-003 Port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port rx, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-005 Port data, output, 8 bits: last received data byte.
REQ-006 Port valid, output, 1 bit: single-cycle pulse marking a completed frame.
REQ-007 Port parity_err, output, 1 bit: parity mismatch on the frame marked by valid.
REQ-008 Port frame_err, output, 1 bit: stop bit sampled low on the frame marked by valid.

Function
REQ-009 The frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 even-parity bit and 1 stop bit (1).
REQ-010 rx SHALL pass through a 2-flop synchronizer; all further logic SHALL use only the synchronized value rxs.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and BREAK, driven by a bit-period counter and a 3-bit data index.
REQ-012 IDLE: a 1-to-0 transition on rxs SHALL move the FSM to START and clear the bit-period counter.
REQ-013 START: at count CLKS_PER_BIT/2-1 rxs SHALL be sampled; if 0, go to DATA and clear the counter; if 1, treat it as a glitch and return to IDLE with no valid.
REQ-014 DATA, PARITY and STOP SHALL each sample rxs once per bit, at count CLKS_PER_BIT-1 after the previous sample (mid-bit).
REQ-015 DATA: the sample SHALL be shifted into data bit index 0..7 in order; after index 7 the FSM SHALL go to PARITY.
REQ-016 PARITY: the block SHALL compute p = XOR of the 8 data bits and the sampled parity bit; p=1 SHALL set the internal parity error; the FSM SHALL then go to STOP.
REQ-017 STOP: the block SHALL drive valid=1 for exactly one cycle, the cycle after the stop sample.
REQ-018 In that same cycle data, parity_err and frame_err SHALL present the frame's results.
REQ-019 If the stop sample is 1, the FSM SHALL go to IDLE; if it is 0, it SHALL set frame_err and go to BREAK.
REQ-020 BREAK: the FSM SHALL remain until rxs=1, then go to IDLE, so that a continuous low line yields exactly one frame.
REQ-021 data, parity_err and frame_err SHALL hold their values until the next valid; valid SHALL be 0 in every other cycle.
REQ-022 Frames SHALL be accepted back-to-back: a start edge seen in IDLE immediately after STOP SHALL be received with no lost bits.
REQ-023 The bit-period counter SHALL be sized as clog2(CLKS_PER_BIT) bits and SHALL never wrap during a bit.
REQ-024 rx activity while not in IDLE or BREAK SHALL NOT restart the frame.

Reset
REQ-025 rstn=0 SHALL asynchronously force state=IDLE, counters=0, synchronizer flops=1, data=8'h00, valid=0, parity_err=0 and frame_err=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no valid pulse.
REQ-027 After rstn deasserts, a line held low SHALL NOT be taken as a start bit until rxs has been seen high.

Verification
REQ-028 Send byte 8'hA5 with parity 0 and stop 1 -> one valid pulse; data=8'hA5, parity_err=0, frame_err=0.
REQ-029 Send byte 8'h01 with parity bit 0 (wrong) -> valid; data=8'h01, parity_err=1, frame_err=0.
REQ-030 Send byte 8'h3C with stop bit 0, then hold rx low for 30 bits -> exactly one valid with frame_err=1; no further valid until rx returns high and a new frame is sent.
REQ-031 Drive a low glitch of CLKS_PER_BIT/2-2 cycles on idle rx -> no valid; the next frame 8'hFF (parity 0) is received correctly.
REQ-032 Send 8'h12, 8'h34 and 8'h56 back-to-back -> three valid pulses, with data 12, 34 and 56 in order and both error flags 0.
REQ-033 Assert rstn during DATA of a frame, release it, then send 8'h99 -> no valid for the aborted frame; next valid has data=8'h99 and no errors.

Source files
------------

// File: rtl/serial_parity_rx.sv
// UART-style receiver: start bit, 8 data bits LSB first, even parity, stop bit.
// Reports each completed frame with a one-cycle valid pulse plus parity/framing errors.
module serial_parity_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_fill;
    logic             r_rxsPrev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_parErr;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_parityErrOut;
    logic             r_frameErr;
    logic             w_rxs;
    logic             w_fall;
    logic             w_halfHit;
    logic             w_bitHit;

    assign w_rxs     = r_sync2;
    assign w_halfHit = (r_cnt == HALF_M1);
    assign w_bitHit  = (r_cnt == FULL_M1);
    assign w_fall    = (r_state == IDLE) && r_rxsPrev && !w_rxs;

    // r_fill marks when the synchronizer holds real line samples, so the reset
    // value of the flops is never mistaken for a high line before a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_fill    <= 2'b00;
            r_rxsPrev <= 1'b0;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_fill    <= {r_fill[0], 1'b1};
            r_rxsPrev <= r_fill[1] & r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_next = START;
            START:   if (w_halfHit) w_next = w_rxs ? IDLE : DATA;
            DATA:    if (w_bitHit && (r_idx == 3'd7)) w_next = PARITY;
            PARITY:  if (w_bitHit) w_next = STOP;
            STOP:    if (w_bitHit) w_next = w_rxs ? IDLE : BREAK;
            BREAK:   if (w_rxs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bit timing and capture: each sample lands one full bit after the previous one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt          <= '0;
            r_idx          <= 3'd0;
            r_shift        <= 8'h00;
            r_parErr       <= 1'b0;
            r_data         <= 8'h00;
            r_valid        <= 1'b0;
            r_parityErrOut <= 1'b0;
            r_frameErr     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                START: begin
                    r_cnt <= w_halfHit ? '0 : r_cnt + 1'b1;
                    r_idx <= 3'd0;
                end
                DATA: begin
                    if (w_bitHit) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rxs;
                        r_idx          <= r_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_bitHit) begin
                        r_cnt    <= '0;
                        r_parErr <= (^r_shift) ^ w_rxs;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bitHit) begin
                        r_cnt          <= '0;
                        r_valid        <= 1'b1;
                        r_data         <= r_shift;
                        r_parityErrOut <= r_parErr;
                        r_frameErr     <= !w_rxs;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                    r_idx <= 3'd0;
                end
            endcase
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_parityErrOut;
    assign frame_err  = r_frameErr;

endmodule
